// File: rtl/dmem_responder.sv
// Data-memory responder for the MEM stage: valid/ready request in, one-cycle
// response pulse out after WAIT_CYCLES wait states, byte-lane stores and extended loads.
module dmem_responder #(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [2:0]  req_size,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        busy
);

  localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t      state, state_nxt;
  logic [3:0]  cnt;
  logic        lat_we;
  logic [31:0] lat_addr;
  logic [31:0] lat_wdata;
  logic [2:0]  lat_size;

  logic [31:0] mem [DEPTH_WORDS];

  logic          commit;
  logic          fault;
  logic          wr_en;
  logic [AW-1:0] widx;
  logic [31:0]   rd_word;
  logic [31:0]   ld_data;
  logic [31:0]   wr_data;
  logic [3:0]    lanes;
  logic [7:0]    sel_byte;
  logic [15:0]   sel_half;

  always_comb begin
    state_nxt  = state;
    req_ready  = 1'b0;
    busy       = 1'b0;
    resp_valid = 1'b0;
    commit     = 1'b0;
    case (state)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_nxt = S_WAIT;
      end
      S_WAIT: begin
        busy = 1'b1;
        if (cnt == 4'd0) begin
          commit    = 1'b1;
          state_nxt = S_RESP;
        end
      end
      S_RESP: begin
        busy       = 1'b1;
        resp_valid = 1'b1;
        state_nxt  = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Fault classification on the latched request.
  always_comb begin
    fault = 1'b0;
    if (lat_size == 3'b011 || lat_size[2:1] == 2'b11) fault = 1'b1;
    if (lat_size[1:0] == 2'b01 && lat_addr[0]) fault = 1'b1;
    if (lat_size == 3'b010 && lat_addr[1:0] != 2'b00) fault = 1'b1;
    if (lat_we && lat_size[2]) fault = 1'b1;
    if ({2'b00, lat_addr[31:2]} >= 32'(DEPTH_WORDS)) fault = 1'b1;
  end

  assign widx    = lat_addr[AW+1:2];
  assign rd_word = mem[widx];
  // A reset on the commit edge drops the access entirely.
  assign wr_en   = commit && !reset && lat_we && !fault;

  always_comb begin
    case (lat_addr[1:0])
      2'd0:    sel_byte = rd_word[7:0];
      2'd1:    sel_byte = rd_word[15:8];
      2'd2:    sel_byte = rd_word[23:16];
      default: sel_byte = rd_word[31:24];
    endcase
    sel_half = lat_addr[1] ? rd_word[31:16] : rd_word[15:0];
    case (lat_size)
      3'b000:  ld_data = {{24{sel_byte[7]}}, sel_byte};
      3'b001:  ld_data = {{16{sel_half[15]}}, sel_half};
      3'b010:  ld_data = rd_word;
      3'b100:  ld_data = {24'd0, sel_byte};
      3'b101:  ld_data = {16'd0, sel_half};
      default: ld_data = 32'd0;
    endcase
  end

  always_comb begin
    case (lat_size[1:0])
      2'b00: begin
        lanes   = 4'b0001 << lat_addr[1:0];
        wr_data = {4{lat_wdata[7:0]}};
      end
      2'b01: begin
        lanes   = lat_addr[1] ? 4'b1100 : 4'b0011;
        wr_data = {2{lat_wdata[15:0]}};
      end
      default: begin
        lanes   = 4'b1111;
        wr_data = lat_wdata;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      cnt        <= 4'd0;
      lat_we     <= 1'b0;
      lat_addr   <= 32'd0;
      lat_wdata  <= 32'd0;
      lat_size   <= 3'd0;
      resp_rdata <= 32'd0;
      resp_err   <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == S_IDLE && req_valid) begin
        lat_we    <= req_we;
        lat_addr  <= req_addr;
        lat_wdata <= req_wdata;
        lat_size  <= req_size;
        cnt       <= 4'(WAIT_CYCLES);
      end else if (state == S_WAIT && cnt != 4'd0) begin
        cnt <= cnt - 4'd1;
      end
      if (commit) begin
        resp_err   <= fault;
        resp_rdata <= (fault || lat_we) ? 32'd0 : ld_data;
      end
    end
  end

  // The array has no reset; contents survive a reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int i = 0; i < 4; i++) begin
        if (lanes[i]) mem[widx][8*i +: 8] <= wr_data[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: directed scenarios plus randomized
// traffic against a byte-addressed reference model; also a zero-wait-state instance.
module tb_dmem_responder;

  localparam int DEPTH = 1024;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        req_valid = 1'b0, req_we = 1'b0;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic [2:0]  req_size = '0;
  logic        req_ready, resp_valid, resp_err, busy;
  logic [31:0] resp_rdata;

  logic        z_valid = 1'b0, z_we = 1'b0;
  logic [31:0] z_addr = '0, z_wdata = '0;
  logic [2:0]  z_size = '0;
  logic        z_ready, z_rvalid, z_err, z_busy;
  logic [31:0] z_rdata;

  int n_checks = 0;
  int n_pass = 0;

  logic [7:0] bmem [int];

  always #5 clk = ~clk;

  dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(1)) u_dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata), .req_size(req_size),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err), .busy(busy));

  dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(0)) u_dut0 (
    .clk(clk), .reset(reset), .req_valid(z_valid), .req_ready(z_ready),
    .req_we(z_we), .req_addr(z_addr), .req_wdata(z_wdata), .req_size(z_size),
    .resp_valid(z_rvalid), .resp_rdata(z_rdata), .resp_err(z_err), .busy(z_busy));

  // Reference model: little-endian byte memory, rules taken straight from the ISA semantics.
  function automatic void model(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                                input logic [2:0] size, output logic [31:0] rd, output logic err);
    int unsigned a = addr;
    int nb = 4;
    logic [31:0] v = 32'd0;
    bit bad = 0;
    case (size)
      3'd0, 3'd4: nb = 1;
      3'd1, 3'd5: nb = 2;
      3'd2:       nb = 4;
      default:    bad = 1;
    endcase
    if (we && size > 3'd2) bad = 1;
    if (!bad && (a % nb) != 0) bad = 1;
    if (a / 4 >= DEPTH) bad = 1;
    err = bad;
    rd = 32'd0;
    if (bad) return;
    if (we) begin
      for (int i = 0; i < nb; i++) bmem[a + i] = wdata[8*i +: 8];
    end else begin
      for (int i = 0; i < nb; i++) v = v | (32'(bmem[a + i]) << (8 * i));
      if (size == 3'd0 && v[7]) v = v | 32'hFFFF_FF00;
      if (size == 3'd1 && v[15]) v = v | 32'hFFFF_0000;
      rd = v;
    end
  endfunction

  task automatic drive(input bit z, input logic v, input logic we, input logic [31:0] a,
                       input logic [31:0] d, input logic [2:0] s);
    if (z) begin
      z_valid = v; z_we = we; z_addr = a; z_wdata = d; z_size = s;
    end else begin
      req_valid = v; req_we = we; req_addr = a; req_wdata = d; req_size = s;
    end
  endtask

  // One transaction: returns response data, error, accept-to-pulse latency (-1 on timeout)
  // and the number of further pulses seen in the three cycles after the response.
  task automatic xact(input bit z, input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [2:0] size, output logic [31:0] rdata, output logic err,
                      output int lat, output int extra);
    int n = 0;
    rdata = 32'hX; err = 1'bX; lat = -1; extra = 0;
    @(negedge clk);
    drive(z, 1'b1, we, addr, wdata, size);
    while (!(z ? z_ready : req_ready) && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      drive(z, 1'b0, 1'b0, 32'd0, 32'd0, 3'd0);
      return;
    end
    @(posedge clk);
    #1;
    // Scramble inputs after accept; the latched copy must be used.
    drive(z, 1'b0, ~we, $urandom, $urandom, 3'($urandom_range(0, 7)));
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk);
      #1;
      if (z ? z_rvalid : resp_valid) begin
        lat = k;
        rdata = z ? z_rdata : resp_rdata;
        err = z ? z_err : resp_err;
        break;
      end
    end
    repeat (3) begin
      @(posedge clk);
      #1;
      if (z ? z_rvalid : resp_valid) extra++;
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if ({req_ready, resp_valid, resp_err, busy, resp_rdata} !== {1'b1, 1'b0, 1'b0, 1'b0, 32'd0})
      $display("FAIL reset_outputs got rdy=%b rv=%b err=%b busy=%b rd=%h want 1 0 0 0 00000000",
               req_ready, resp_valid, resp_err, busy, resp_rdata);
    else n_pass++;
    n_checks++;
    if ({z_ready, z_rvalid, z_busy} !== 3'b100)
      $display("FAIL reset_outputs_w0 got rdy=%b rv=%b busy=%b want 1 0 0", z_ready, z_rvalid, z_busy);
    else n_pass++;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_basic();
    logic [31:0] rd, exp_rd; logic err, exp_err; int lat, extra;
    model(1'b1, 32'h10, 32'hDEADBEEF, 3'd2, exp_rd, exp_err);
    xact(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 3'd2, rd, err, lat, extra);
    n_checks++;
    if (lat !== 2 || err !== 1'b0 || rd !== 32'd0 || extra !== 0)
      $display("FAIL sw_basic got lat=%0d err=%b rd=%h extra=%0d want lat=2 err=0 rd=0 extra=0", lat, err, rd, extra);
    else n_pass++;
    xact(1'b0, 1'b0, 32'h10, 32'h0, 3'd2, rd, err, lat, extra);
    n_checks++;
    if (lat !== 2 || err !== 1'b0 || rd !== 32'hDEADBEEF || extra !== 0)
      $display("FAIL lw_basic got lat=%0d err=%b rd=%h extra=%0d want lat=2 err=0 rd=deadbeef extra=0", lat, err, rd, extra);
    else n_pass++;
  endtask

  task automatic test_extend();
    logic [2:0]  sz [4] = '{3'd0, 3'd4, 3'd1, 3'd5};
    logic [31:0] ad [4] = '{32'h13, 32'h13, 32'h12, 32'h10};
    logic [31:0] ex [4] = '{32'hFFFFFFDE, 32'h000000DE, 32'hFFFFDEAD, 32'h0000BEEF};
    logic [31:0] rd; logic err; int lat, extra;
    for (int i = 0; i < 4; i++) begin
      xact(1'b0, 1'b0, ad[i], 32'h0, sz[i], rd, err, lat, extra);
      n_checks++;
      if (rd !== ex[i] || err !== 1'b0 || lat !== 2)
        $display("FAIL load_ext%0d got rd=%h err=%b lat=%0d want rd=%h err=0 lat=2", i, rd, err, lat, ex[i]);
      else n_pass++;
    end
  endtask

  task automatic test_store_lanes();
    logic [31:0] rd, mrd; logic err, merr; int lat, extra;
    model(1'b1, 32'h11, 32'hFFFFFF55, 3'd0, mrd, merr);
    xact(1'b0, 1'b1, 32'h11, 32'hFFFFFF55, 3'd0, rd, err, lat, extra);
    xact(1'b0, 1'b0, 32'h10, 32'h0, 3'd2, rd, err, lat, extra);
    n_checks++;
    if (rd !== 32'hDEAD55EF || err !== 1'b0)
      $display("FAIL sb_lane got rd=%h err=%b want rd=dead55ef err=0", rd, err);
    else n_pass++;
    model(1'b1, 32'h12, 32'hABCD1234, 3'd1, mrd, merr);
    xact(1'b0, 1'b1, 32'h12, 32'hABCD1234, 3'd1, rd, err, lat, extra);
    xact(1'b0, 1'b0, 32'h10, 32'h0, 3'd2, rd, err, lat, extra);
    n_checks++;
    if (rd !== 32'h123455EF || err !== 1'b0)
      $display("FAIL sh_lane got rd=%h err=%b want rd=123455ef err=0", rd, err);
    else n_pass++;
  endtask

  task automatic test_faults();
    logic        we [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
    logic [31:0] ad [4] = '{32'h12, 32'h11, 32'(4 * DEPTH), 32'h10};
    logic [2:0]  sz [4] = '{3'd2, 3'd1, 3'd2, 3'd4};
    logic [31:0] rd; logic err; int lat, extra;
    for (int i = 0; i < 4; i++) begin
      xact(1'b0, we[i], ad[i], 32'hFFFFFFFF, sz[i], rd, err, lat, extra);
      n_checks++;
      if (err !== 1'b1 || rd !== 32'd0 || lat !== 2)
        $display("FAIL fault%0d got err=%b rd=%h lat=%0d want err=1 rd=0 lat=2", i, err, rd, lat);
      else n_pass++;
    end
    xact(1'b0, 1'b0, 32'h10, 32'h0, 3'd2, rd, err, lat, extra);
    n_checks++;
    if (rd !== 32'h123455EF || err !== 1'b0)
      $display("FAIL fault_nowrite got rd=%h err=%b want rd=123455ef err=0", rd, err);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [31:0] rd, mrd; logic err, merr; int lat, extra;
    logic [31:0] pd [2];
    int pulses = 0, acc = 1, acc_cyc = -1, p1_cyc = -1, ready_bad = 0;
    model(1'b1, 32'h14, 32'h0BADCAFE, 3'd2, mrd, merr);
    xact(1'b0, 1'b1, 32'h14, 32'h0BADCAFE, 3'd2, rd, err, lat, extra);
    pd[0] = 32'hX; pd[1] = 32'hX;
    @(negedge clk);
    drive(1'b0, 1'b1, 1'b0, 32'h10, 32'h0, 3'd2);
    @(posedge clk);
    #1;
    req_addr = 32'h14;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (c == 0) begin
        n_checks++;
        if (req_ready !== 1'b0) $display("FAIL hold_ready_wait got %b want 0", req_ready);
        else n_pass++;
      end
      if (busy && req_ready) ready_bad++;
      if (req_ready && req_valid) begin
        acc++;
        acc_cyc = c;
      end
      @(posedge clk);
      #1;
      if (acc == 2 && req_valid) req_valid = 1'b0;
      if (resp_valid) begin
        if (pulses < 2) pd[pulses] = resp_rdata;
        if (pulses == 0) p1_cyc = c;
        pulses++;
      end
    end
    req_valid = 1'b0;
    n_checks++;
    if (pulses !== 2 || acc !== 2)
      $display("FAIL hold_pulses got pulses=%0d accepts=%0d want 2 2", pulses, acc);
    else n_pass++;
    n_checks++;
    if (pd[0] !== 32'h123455EF || pd[1] !== 32'h0BADCAFE)
      $display("FAIL hold_data got %h %h want 123455ef 0badcafe", pd[0], pd[1]);
    else n_pass++;
    n_checks++;
    if (ready_bad !== 0 || acc_cyc <= p1_cyc)
      $display("FAIL hold_order got ready_while_busy=%0d acc_cyc=%0d resp_cyc=%0d want 0 and acc after resp",
               ready_bad, acc_cyc, p1_cyc);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd, mrd; logic err, merr; int lat, extra, pulses = 0;
    model(1'b1, 32'h20, 32'h11111111, 3'd2, mrd, merr);
    xact(1'b0, 1'b1, 32'h20, 32'h11111111, 3'd2, rd, err, lat, extra);
    xact(1'b0, 1'b0, 32'h20, 32'h0, 3'd2, rd, err, lat, extra);
    n_checks++;
    if (rd !== 32'h11111111) $display("FAIL rst_pre_load got %h want 11111111", rd);
    else n_pass++;
    @(negedge clk);
    drive(1'b0, 1'b1, 1'b1, 32'h20, 32'hCAFEF00D, 3'd2);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    reset = 1'b1;
    repeat (2) begin
      @(posedge clk);
      #1;
      if (resp_valid) pulses++;
    end
    n_checks++;
    if ({req_ready, resp_valid, resp_err, busy, resp_rdata} !== {1'b1, 1'b0, 1'b0, 1'b0, 32'd0})
      $display("FAIL rst_mid_outputs got rdy=%b rv=%b err=%b busy=%b rd=%h want 1 0 0 0 00000000",
               req_ready, resp_valid, resp_err, busy, resp_rdata);
    else n_pass++;
    @(negedge clk);
    reset = 1'b0;
    repeat (3) begin
      @(posedge clk);
      #1;
      if (resp_valid) pulses++;
    end
    n_checks++;
    if (pulses !== 0) $display("FAIL rst_mid_pulse got %0d pulses want 0", pulses);
    else n_pass++;
    xact(1'b0, 1'b0, 32'h20, 32'h0, 3'd2, rd, err, lat, extra);
    n_checks++;
    if (rd !== 32'h11111111 || err !== 1'b0)
      $display("FAIL rst_mid_nowrite got rd=%h err=%b want rd=11111111 err=0", rd, err);
    else n_pass++;
  endtask

  task automatic test_random();
    logic [31:0] rd, mrd, a, d; logic err, merr, we; logic [2:0] sz; int lat, extra;
    for (int w = 0; w < 32; w++) begin
      d = $urandom;
      model(1'b1, 32'(4 * w), d, 3'd2, mrd, merr);
      xact(1'b0, 1'b1, 32'(4 * w), d, 3'd2, rd, err, lat, extra);
    end
    for (int i = 0; i < 60; i++) begin
      we = 1'($urandom_range(0, 1));
      sz = 3'($urandom_range(0, 7));
      d = $urandom;
      if ($urandom_range(0, 7) == 0) a = 32'(4 * DEPTH + $urandom_range(0, 15));
      else a = 32'($urandom_range(0, 127));
      model(we, a, d, sz, mrd, merr);
      xact(1'b0, we, a, d, sz, rd, err, lat, extra);
      n_checks++;
      if (rd !== mrd || err !== merr)
        $display("FAIL rand%0d we=%b a=%h sz=%0d got rd=%h err=%b want rd=%h err=%b", i, we, a, sz, rd, err, mrd, merr);
      else n_pass++;
      n_checks++;
      if (lat !== 2 || extra !== 0)
        $display("FAIL rand_timing%0d got lat=%0d extra=%0d want 2 0", i, lat, extra);
      else n_pass++;
    end
  endtask

  task automatic test_zero_wait();
    logic [31:0] rd; logic err; int lat, extra;
    xact(1'b1, 1'b1, 32'h8, 32'hA5A5A5A5, 3'd2, rd, err, lat, extra);
    n_checks++;
    if (lat !== 1 || err !== 1'b0 || extra !== 0)
      $display("FAIL w0_sw got lat=%0d err=%b extra=%0d want 1 0 0", lat, err, extra);
    else n_pass++;
    xact(1'b1, 1'b0, 32'h8, 32'h0, 3'd2, rd, err, lat, extra);
    n_checks++;
    if (lat !== 1 || rd !== 32'hA5A5A5A5)
      $display("FAIL w0_lw got lat=%0d rd=%h want 1 a5a5a5a5", lat, rd);
    else n_pass++;
    xact(1'b1, 1'b0, 32'hB, 32'h0, 3'd0, rd, err, lat, extra);
    n_checks++;
    if (lat !== 1 || rd !== 32'hFFFFFFA5)
      $display("FAIL w0_lb got lat=%0d rd=%h want 1 ffffffa5", lat, rd);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_extend();
    test_store_lanes();
    test_faults();
    test_back_to_back();
    test_reset_mid();
    test_zero_wait();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
